// File: rtl/dft_acc_writer.sv
// ============================================================================
// Module      : dft_acc_writer
// Description : Vector integrator for the single-bin DFT correlator. Sums
//               acc_len frames of 2^ADDR_WIDTH complex samples per channel
//               in an internal memory. The final frame of each integration
//               is streamed to readout RAM port A as {im, re} words.
//               Optional macro DFT_ACC_SATURATE_EN: saturating adds instead
//               of two's-complement wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dft_acc_writer #(
    parameter int DIN_WIDTH  = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic signed [DIN_WIDTH-1:0]   din_re,
    input  logic signed [DIN_WIDTH-1:0]   din_im,
    input  logic                          din_valid,
    input  logic                          sync,
    input  logic [31:0]                   acc_len,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic [2*ACC_WIDTH-1:0]        bram_din,
    output logic                          bram_we,
    output logic                          acc_done,
    output logic                          acc_ovf
);

    localparam int DOUT_WIDTH = 2 * ACC_WIDTH;
    localparam int NUM_CH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_CH = ADDR_WIDTH'(NUM_CH - 1);
`ifdef DFT_ACC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Add one component; returns {overflow, result}.
    function automatic logic [ACC_WIDTH:0] acc_add(
        input logic [ACC_WIDTH-1:0] base,
        input logic [ACC_WIDTH-1:0] addend
    );
        logic [ACC_WIDTH:0]   sum;
        logic                 ovf;
        logic [ACC_WIDTH-1:0] res;
        sum = {base[ACC_WIDTH-1], base} + {addend[ACC_WIDTH-1], addend};
        ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
`ifdef DFT_ACC_SATURATE_EN
        res = ovf ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
`else
        res = sum[ACC_WIDTH-1:0];
`endif
        return {ovf, res};
    endfunction

    // Control state
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_chan;
    logic [ADDR_WIDTH-1:0] w_chan_nxt;
    logic [31:0]           r_frame;
    logic [31:0]           w_frame_nxt;
    logic [31:0]           r_len;
    logic [31:0]           w_len_nxt;
    logic                  r_pend;

    // Stage-0 decode of the incoming sample
    logic                  w_accept;
    logic                  w_abort;
    logic                  w_start;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_frame_cur;
    logic [31:0]           w_len_cur;
    logic [31:0]           w_len_eff;
    logic                  w_first;
    logic                  w_last;
    logic                  w_lastch;

    // Stage-1 registers (sample plus memory read data)
    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_idx;
    logic                  r_s1_first;
    logic                  r_s1_last;
    logic                  r_s1_lastch;
    logic                  r_s1_start;
    logic signed [DIN_WIDTH-1:0] r_s1_re;
    logic signed [DIN_WIDTH-1:0] r_s1_im;
    logic [ACC_WIDTH-1:0]  r_rd_re;
    logic [ACC_WIDTH-1:0]  r_rd_im;

    // Stage-1 arithmetic
    logic                  w_s1_live;
    logic signed [ACC_WIDTH-1:0] w_ext_re;
    logic signed [ACC_WIDTH-1:0] w_ext_im;
    logic [ACC_WIDTH-1:0]  w_base_re;
    logic [ACC_WIDTH-1:0]  w_base_im;
    logic [ACC_WIDTH:0]    w_add_re;
    logic [ACC_WIDTH:0]    w_add_im;
    logic [ACC_WIDTH-1:0]  w_res_re;
    logic [ACC_WIDTH-1:0]  w_res_im;
    logic                  w_ovf_now;
    logic                  w_pend_prev;

    // Accumulator storage; deliberately not reset since the first frame loads.
    logic [ACC_WIDTH-1:0]  mem_re [NUM_CH];
    logic [ACC_WIDTH-1:0]  mem_im [NUM_CH];

    // Next-state decode: sample acceptance, restart handling and counters
    always_comb begin
        w_state_nxt = r_state;
        w_chan_nxt  = r_chan;
        w_frame_nxt = r_frame;
        w_len_nxt   = r_len;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_start     = 1'b0;
        w_idx       = r_chan;
        w_frame_cur = r_frame;
        w_len_cur   = r_len;
        w_len_eff   = (acc_len == 32'd0) ? 32'd1 : acc_len;
        w_first     = 1'b0;
        w_last      = 1'b0;
        w_lastch    = 1'b0;

        if (din_valid) begin
            if (sync) begin
                w_accept    = 1'b1;
                w_start     = 1'b1;
                w_idx       = '0;
                w_frame_cur = 32'd0;
                // A sync anywhere but an integration boundary throws away the partial run.
                w_abort     = (r_state == ST_RUN) && ((r_chan != '0) || (r_frame != 32'd0));
            end else if (r_state == ST_RUN) begin
                w_accept = 1'b1;
                w_start  = (r_chan == '0) && (r_frame == 32'd0);
            end
        end

        if (w_accept) begin
            w_state_nxt = ST_RUN;
            if (w_start) begin
                w_len_cur = w_len_eff;
                w_len_nxt = w_len_eff;
            end
            w_first    = (w_frame_cur == 32'd0);
            w_last     = (w_frame_cur == (w_len_cur - 32'd1));
            w_lastch   = (w_idx == LAST_CH);
            w_chan_nxt = w_idx + 1'b1;
            if (w_lastch) begin
                w_frame_nxt = w_last ? 32'd0 : (w_frame_cur + 32'd1);
            end else begin
                w_frame_nxt = w_frame_cur;
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_chan  <= '0;
            r_frame <= 32'd0;
            r_len   <= 32'd1;
        end else begin
            r_state <= w_state_nxt;
            r_chan  <= w_chan_nxt;
            r_frame <= w_frame_nxt;
            r_len   <= w_len_nxt;
        end
    end

    // Stage-1 control flags; cleared on reset so no in-flight write survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_lastch <= 1'b0;
            r_s1_start  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_idx    <= w_idx;
                r_s1_first  <= w_first;
                r_s1_last   <= w_last;
                r_s1_lastch <= w_lastch;
                r_s1_start  <= w_start;
            end
        end
    end

    // The stage-1 sample is killed when a restart sync arrives behind it.
    assign w_s1_live = r_s1_valid && !w_abort;

    assign w_ext_re  = ACC_WIDTH'(r_s1_re);
    assign w_ext_im  = ACC_WIDTH'(r_s1_im);
    assign w_base_re = r_s1_first ? '0 : r_rd_re;
    assign w_base_im = r_s1_first ? '0 : r_rd_im;
    assign w_add_re  = acc_add(w_base_re, w_ext_re);
    assign w_add_im  = acc_add(w_base_im, w_ext_im);
    assign w_res_re  = w_add_re[ACC_WIDTH-1:0];
    assign w_res_im  = w_add_im[ACC_WIDTH-1:0];
    assign w_ovf_now = w_add_re[ACC_WIDTH] | w_add_im[ACC_WIDTH];
    assign w_pend_prev = r_s1_start ? 1'b0 : r_pend;

    // Accumulator memory: write-back of stage 1, read-first with collision bypass
    always_ff @(posedge clk) begin
        if (w_s1_live) begin
            mem_re[r_s1_idx] <= w_res_re;
            mem_im[r_s1_idx] <= w_res_im;
        end
        if (w_accept) begin
            r_s1_re <= din_re;
            r_s1_im <= din_im;
            if (w_s1_live && (r_s1_idx == w_idx)) begin
                r_rd_re <= w_res_re;
                r_rd_im <= w_res_im;
            end else begin
                r_rd_re <= mem_re[w_idx];
                r_rd_im <= mem_im[w_idx];
            end
        end
    end

    // Output stage: RAM port A write, done pulse and overflow reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_addr <= '0;
            bram_din  <= '0;
            bram_we   <= 1'b0;
            acc_done  <= 1'b0;
            acc_ovf   <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            bram_we  <= 1'b0;
            acc_done <= 1'b0;
            if (w_s1_live) begin
                r_pend <= w_pend_prev | w_ovf_now;
                if (r_s1_last) begin
                    bram_we   <= 1'b1;
                    bram_addr <= r_s1_idx;
                    bram_din  <= DOUT_WIDTH'({w_res_im, w_res_re});
                    acc_done  <= r_s1_lastch;
                    if (r_s1_lastch) begin
                        acc_ovf <= w_pend_prev | w_ovf_now;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
